fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 166 ++++++++++++++++
 tb/tb_fetch_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Decouples the program counter from instruction memory and Decode. Fetch
//   requests are issued only while a credit is available, so every response
//   is guaranteed a free slot in the instruction queue. Responses return in
//   order and are paired with the PC recorded when the request fired. A flush
//   empties the queue and turns every in-flight request into one to discard.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   pc_valid, pc_in, pc_ready   fetch address handshake from the PC stage
//   imem_req_valid/addr/ready   request channel to instruction memory
//   imem_rsp_valid/data         in-order response channel from memory
//   flush                       redirect from Execute
//   dec_valid/instr/pc/ready    instruction handshake to Decode
//
// Parameter
//   DEPTH   queue depth and in-flight credit limit (power of two, 2..16)
//
// Optional feature macro
//   FETCH_BYPASS_EN   when defined, a live response arriving at an empty
//                     queue with Decode ready is forwarded in the same cycle
// -----------------------------------------------------------------------------
module fetch_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_valid,
   input  logic [31:0] pc_in,
   output logic        pc_ready,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        flush,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   input  logic        dec_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   // Wide enough to hold count+live+drop without wrapping.
   localparam int SW = PW + 3;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   cnt_t count_q, count_d;
   cnt_t live_q,  live_d;
   cnt_t drop_q,  drop_d;
   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   ptr_t pf_wr_q,  pf_wr_d;
   ptr_t pf_rd_q,  pf_rd_d;

   logic [31:0] q_instr_q [DEPTH];
   logic [31:0] q_pc_q    [DEPTH];
   logic [31:0] pf_pc_q   [DEPTH];

   logic          credit;
   logic          fire;
   logic          rsp_drop;
   logic          rsp_live;
   logic          bypass;
   logic          push;
   logic          pop;
   logic [SW-1:0] occupancy;

   always_comb begin
      occupancy      = SW'(count_q) + SW'(live_q) + SW'(drop_q);
      credit         = (occupancy < SW'(DEPTH));
      imem_req_valid = pc_valid & credit & ~flush & rst_n;
      imem_req_addr  = {pc_in[31:2], 2'b00};
      pc_ready       = imem_req_valid & imem_req_ready;
      fire           = pc_ready;

      // Discarding owed responses takes priority over accepting live ones.
      rsp_drop = imem_rsp_valid & (drop_q != '0);
      rsp_live = imem_rsp_valid & (drop_q == '0) & (live_q != '0);

`ifdef FETCH_BYPASS_EN
      bypass = rst_n & (count_q == '0) & rsp_live & dec_ready & ~flush;
`else
      bypass = 1'b0;
`endif

      push = rsp_live & ~flush & ~bypass;
      pop  = (count_q != '0) & dec_ready & ~flush;

      dec_valid = rst_n & ((count_q != '0) | bypass);
      dec_instr = '0;
      dec_pc    = '0;
      if (rst_n && (count_q != '0)) begin
         dec_instr = q_instr_q[rd_ptr_q];
         dec_pc    = q_pc_q[rd_ptr_q];
      end else if (bypass) begin
         dec_instr = imem_rsp_data;
         dec_pc    = pf_pc_q[pf_rd_q];
      end
   end

   always_comb begin
      count_d  = count_q;
      live_d   = live_q;
      drop_d   = drop_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      pf_wr_d  = pf_wr_q;
      pf_rd_d  = pf_rd_q;
      if (flush) begin
         // Every live request becomes one to discard; a response arriving
         // right now retires one of them immediately.
         count_d  = '0;
         live_d   = '0;
         drop_d   = drop_q + live_q - CW'(rsp_drop | rsp_live);
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         pf_wr_d  = '0;
         pf_rd_d  = '0;
      end else begin
         count_d = count_q + CW'(push) - CW'(pop);
         live_d  = live_q + CW'(fire) - CW'(rsp_live);
         drop_d  = drop_q - CW'(rsp_drop);
         if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
         if (fire)     pf_wr_d  = pf_wr_q + PW'(1);
         if (rsp_live) pf_rd_d  = pf_rd_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= '0;
         live_q   <= '0;
         drop_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         pf_wr_q  <= '0;
         pf_rd_q  <= '0;
      end else begin
         count_q  <= count_d;
         live_q   <= live_d;
         drop_q   <= drop_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pf_wr_q  <= pf_wr_d;
         pf_rd_q  <= pf_rd_d;
      end
   end

   // Storage carries no reset; outputs are masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         q_instr_q[wr_ptr_q] <= imem_rsp_data;
         q_pc_q[wr_ptr_q]    <= pf_pc_q[pf_rd_q];
      end
      if (fire) begin
         pf_pc_q[pf_wr_q] <= pc_in;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

   logic        clk;
   logic        rst_n;
   logic        pc_valid;
   logic [31:0] pc_in;
   logic        pc_ready;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        flush;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        dec_ready;

   fetch_buffer #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc_valid       (pc_valid),
      .pc_in          (pc_in),
      .pc_ready       (pc_ready),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .flush          (flush),
      .dec_valid      (dec_valid),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_ready      (dec_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   mreq_t mem_q[$];
   ent_t  exp_q[$];
   ent_t  got_exp[$];
   ent_t  got_act[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int lat     = 1;
   int fires   = 0;
   int first_dv_cyc = -1;
   bit force_rsp    = 1'b0;
   bit rsp_from_mem = 1'b0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      if (a == 32'h20) return 32'h0000_0013;
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   // One clock cycle: sample at the falling edge, then advance the memory
   // model just after the rising edge.
   task automatic cycle();
      @(negedge clk);
      if (imem_rsp_valid && rsp_from_mem && mem_q.size() > 0) void'(mem_q.pop_front());
      if (flush) exp_q.delete();
      if (dec_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
      if (dec_valid && dec_ready && !flush) begin
         if (exp_q.size() > 0) got_exp.push_back(exp_q.pop_front());
         else got_exp.push_back('{pc: 32'hDEAD_DEAD, instr: 32'hDEAD_DEAD});
         got_act.push_back('{pc: dec_pc, instr: dec_instr});
      end
      if (imem_req_valid && imem_req_ready) begin
         mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
         exp_q.push_back('{pc: pc_in, instr: instr_of({pc_in[31:2], 2'b00})});
         fires++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (force_rsp) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'h0BAD_0000;
         rsp_from_mem   = 1'b0;
         force_rsp      = 1'b0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(mem_q[0].addr);
         rsp_from_mem   = 1'b1;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
         rsp_from_mem   = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic start_test();
      got_exp.delete();
      got_act.delete();
      fires = 0;
      first_dv_cyc = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pc_valid = 1'b1; pc_in = 32'h10; dec_ready = 1'b1; force_rsp = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %0b want 0", imem_req_valid); end
         n_tests++;
         if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pc_ready: got %0b want 0", pc_ready); end
         n_tests++;
         if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %0b want 0", dec_valid); end
         cycle();
      end
      rst_n = 1'b1; pc_valid = 1'b0;
      mem_q.delete(); exp_q.delete();
      #1;
      n_tests++;
      if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_dec_valid: got %0b want 0", dec_valid); end
      n_tests++;
      if (dec_instr !== 32'h0 || dec_pc !== 32'h0) begin n_fail++; $display("FAIL post_reset_dec_data: got %h/%h want 0/0", dec_instr, dec_pc); end
      n_tests++;
      if (dut.count_q !== '0 || dut.live_q !== '0 || dut.drop_q !== '0) begin
         n_fail++; $display("FAIL post_reset_counters: got %0d/%0d/%0d want 0/0/0", dut.count_q, dut.live_q, dut.drop_q);
      end
      cycle();
   endtask

   task automatic test_in_order();
      int req_cyc;
      start_test();
      lat = 1; dec_ready = 1'b1; req_cyc = 0;
      for (int i = 0; i < 3; i++) begin
         pc_valid = 1'b1; pc_in = 32'(i * 4);
         #1;
         if (i == 0) req_cyc = cyc;
         n_tests++;
         if (pc_ready !== 1'b1 || imem_req_addr !== 32'(i * 4)) begin
            n_fail++; $display("FAIL in_order_issue%0d: got rdy=%0b addr=%h want rdy=1 addr=%h", i, pc_ready, imem_req_addr, 32'(i * 4));
         end
         cycle();
      end
      pc_valid = 1'b0;
      idle(8);
      n_tests++;
      if (got_act.size() !== 3) begin n_fail++; $display("FAIL in_order_count: got %0d want 3", got_act.size()); end
      for (int i = 0; i < got_act.size(); i++) begin
         n_tests++;
         if (got_act[i].pc !== got_exp[i].pc || got_act[i].instr !== got_exp[i].instr) begin
            n_fail++; $display("FAIL in_order_data%0d: got %h/%h want %h/%h", i, got_act[i].pc, got_act[i].instr, got_exp[i].pc, got_exp[i].instr);
         end
      end
      n_tests++;
`ifdef FETCH_BYPASS_EN
      if (first_dv_cyc - req_cyc !== 1) begin n_fail++; $display("FAIL in_order_latency: got %0d want 1", first_dv_cyc - req_cyc); end
`else
      if (first_dv_cyc - req_cyc !== 2) begin n_fail++; $display("FAIL in_order_latency: got %0d want 2", first_dv_cyc - req_cyc); end
`endif
   endtask

   task automatic test_credit();
      logic [31:0] pc;
      bit fired;
      start_test();
      lat = 1; dec_ready = 1'b0; pc = 32'h40;
      for (int i = 0; i < 12; i++) begin
         pc_valid = 1'b1; pc_in = pc;
         #1;
         fired = pc_ready;
         if (i >= 8) begin
            n_tests++;
            if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL credit_pc_ready_c%0d: got %0b want 0", i, pc_ready); end
         end
         cycle();
         if (fired) pc = pc + 32'h4;
      end
      pc_valid = 1'b0;
      #1;
      n_tests++;
      if (fires !== 4) begin n_fail++; $display("FAIL credit_fires: got %0d want 4", fires); end
      n_tests++;
      if (dut.count_q !== 3'd4) begin n_fail++; $display("FAIL credit_count: got %0d want 4", dut.count_q); end
      dec_ready = 1'b1;
      idle(8);
      n_tests++;
      if (got_act.size() !== 4) begin n_fail++; $display("FAIL credit_drain_count: got %0d want 4", got_act.size()); end
      for (int i = 0; i < got_act.size(); i++) begin
         n_tests++;
         if (got_act[i].pc !== got_exp[i].pc || got_act[i].instr !== got_exp[i].instr) begin
            n_fail++; $display("FAIL credit_data%0d: got %h/%h want %h/%h", i, got_act[i].pc, got_act[i].instr, got_exp[i].pc, got_exp[i].instr);
         end
      end
   endtask

   task automatic test_flush_inflight();
      start_test();
      lat = 3; dec_ready = 1'b1;
      pc_valid = 1'b1; pc_in = 32'h200; cycle();
      pc_in = 32'h204; cycle();
      pc_valid = 1'b0; flush = 1'b1; cycle();
      flush = 1'b0;
      #1;
      n_tests++;
      if (dut.drop_q !== 3'd2 || dut.live_q !== 3'd0) begin
         n_fail++; $display("FAIL flush_drop_after: got drop=%0d live=%0d want 2/0", dut.drop_q, dut.live_q);
      end
      pc_valid = 1'b1; pc_in = 32'h100;
      #1;
      n_tests++;
      if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL flush_new_req: got %0b want 1", pc_ready); end
      cycle();
      pc_valid = 1'b0;
      idle(8);
      n_tests++;
      if (dut.drop_q !== 3'd0) begin n_fail++; $display("FAIL flush_drop_final: got %0d want 0", dut.drop_q); end
      n_tests++;
      if (got_act.size() !== 1) begin n_fail++; $display("FAIL flush_deliver_count: got %0d want 1", got_act.size()); end
      if (got_act.size() > 0) begin
         n_tests++;
         if (got_act[0].pc !== 32'h100 || got_act[0].instr !== got_exp[0].instr) begin
            n_fail++; $display("FAIL flush_first_pc: got %h/%h want 00000100/%h", got_act[0].pc, got_act[0].instr, got_exp[0].instr);
         end
      end
      lat = 1;
   endtask

   task automatic test_flush_rsp();
      start_test();
      lat = 1; dec_ready = 1'b1;
      pc_valid = 1'b1; pc_in = 32'h300; cycle();
      flush = 1'b1; pc_in = 32'h304;
      #1;
      n_tests++;
      if (imem_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_rsp_setup: got %0b want 1", imem_rsp_valid); end
      n_tests++;
      if (imem_req_valid !== 1'b0 || pc_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_rsp_no_req: got req=%0b rdy=%0b want 0/0", imem_req_valid, pc_ready);
      end
      cycle();
      flush = 1'b0; pc_valid = 1'b0;
      #1;
      n_tests++;
      if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_rsp_dec_valid: got %0b want 0", dec_valid); end
      n_tests++;
      if (dut.drop_q !== 3'd0 || dut.live_q !== 3'd0) begin
         n_fail++; $display("FAIL flush_rsp_counters: got drop=%0d live=%0d want 0/0", dut.drop_q, dut.live_q);
      end
      idle(4);
      n_tests++;
      if (got_act.size() !== 0) begin n_fail++; $display("FAIL flush_rsp_delivered: got %0d want 0", got_act.size()); end
   endtask

   task automatic test_spurious();
      start_test();
      force_rsp = 1'b1;
      cycle();
      #1;
      n_tests++;
      if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL spurious_dec_valid: got %0b want 0", dec_valid); end
      cycle();
      #1;
      n_tests++;
      if (dut.count_q !== '0 || dut.live_q !== '0 || dut.drop_q !== '0 || dec_valid !== 1'b0) begin
         n_fail++; $display("FAIL spurious_counters: got %0d/%0d/%0d dv=%0b want 0/0/0 dv=0", dut.count_q, dut.live_q, dut.drop_q, dec_valid);
      end
   endtask

`ifdef FETCH_BYPASS_EN
   task automatic test_bypass();
      start_test();
      lat = 1; dec_ready = 1'b1;
      pc_valid = 1'b1; pc_in = 32'h20; cycle();
      pc_valid = 1'b0;
      #1;
      n_tests++;
      if (dec_valid !== 1'b1 || dec_instr !== 32'h13 || dec_pc !== 32'h20) begin
         n_fail++; $display("FAIL bypass_same_cycle: got dv=%0b %h/%h want 1 00000013/00000020", dec_valid, dec_instr, dec_pc);
      end
      cycle();
      #1;
      n_tests++;
      if (dut.count_q !== '0 || dec_valid !== 1'b0) begin
         n_fail++; $display("FAIL bypass_count: got %0d dv=%0b want 0 dv=0", dut.count_q, dec_valid);
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic [31:0] pc;
      bit fired;
      int sent;
      start_test();
      lat = 2; pc = 32'h1000; sent = 0;
      for (int i = 0; i < 200 && sent < 20; i++) begin
         pc_valid = 1'b1; pc_in = pc; dec_ready = 1'($urandom_range(0, 1));
         #1;
         fired = pc_ready;
         cycle();
         if (fired) begin pc = pc + 32'h4; sent++; end
      end
      pc_valid = 1'b0; dec_ready = 1'b1;
      idle(20);
      n_tests++;
      if (sent !== 20 || got_act.size() !== 20) begin
         n_fail++; $display("FAIL b2b_count: got sent=%0d delivered=%0d want 20/20", sent, got_act.size());
      end
      for (int i = 0; i < got_act.size(); i++) begin
         n_tests++;
         if (got_act[i].pc !== got_exp[i].pc || got_act[i].instr !== got_exp[i].instr
             || got_act[i].pc !== 32'h1000 + 32'(i * 4)) begin
            n_fail++; $display("FAIL b2b_data%0d: got %h/%h want %h/%h", i, got_act[i].pc, got_act[i].instr, got_exp[i].pc, got_exp[i].instr);
         end
      end
      lat = 1;
   endtask

   initial begin
      rst_n = 1'b0; pc_valid = 1'b0; pc_in = 32'h0; imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; flush = 1'b0; dec_ready = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_in_order();
      test_credit();
      test_flush_inflight();
      test_flush_rsp();
      test_spurious();
`ifdef FETCH_BYPASS_EN
      test_bypass();
`endif
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
